// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: ALU results win, load results queue in an in-order FIFO.
// Optional define WB_BYPASS_EN lets a load skip the empty FIFO when the ALU is idle.
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            busy1,
    output logic            busy2,
    output logic            regWrite,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] writeData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;

    logic [4:0]       fifo_rd_q   [DEPTH];
    logic [XLEN-1:0]  fifo_data_q [DEPTH];

    logic             accept, push, pop, bypass;
    logic [DEPTH-1:0] entry_valid;

    // Ready depends only on the registered count, so a pop this cycle never frees a slot early.
    assign mem_ready = count_q < CNT_W'(DEPTH);
    assign accept    = mem_valid && mem_ready;
    assign pop       = !alu_valid && (count_q != '0);

`ifdef WB_BYPASS_EN
    assign bypass = accept && !alu_valid && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;

    // NOTE: every _d gets a default before the priority chain, so no latch is inferred.
    always_comb begin
        wr_en_d = 1'b0;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        if (alu_valid) begin
            wr_en_d = (alu_rd != 5'd0);
            rd_d    = alu_rd;
            wdata_d = alu_data;
        end else if (pop) begin
            wr_en_d = (fifo_rd_q[rptr_q] != 5'd0);
            rd_d    = fifo_rd_q[rptr_q];
            wdata_d = fifo_data_q[rptr_q];
        end else if (bypass) begin
            wr_en_d = (mem_rd != 5'd0);
            rd_d    = mem_rd;
            wdata_d = mem_data;
        end

        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Slot i is live when its distance from the read pointer (mod DEPTH) is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset         = PTR_W'(i) - rptr_q;
            entry_valid[i] = {1'b0, offset} < count_q;
        end
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (fifo_rd_q[i] == rs1)) busy1 = 1'b1;
            if (entry_valid[i] && (fifo_rd_q[i] == rs2)) busy2 = 1'b1;
        end
        busy1 = busy1 && (rs1 != 5'd0);
        busy2 = busy2 && (rs2 != 5'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            wr_en_q <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            wr_en_q <= wr_en_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
        end
    end

    // NOTE: storage is not reset; entries are only observed while count marks them live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= mem_rd;
            fifo_data_q[wptr_q] <= mem_data;
        end
    end

    assign regWrite  = wr_en_q;
    assign rd        = rd_q;
    assign writeData = wdata_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed vector table, corner sequences, random vs queue model.
module tb_reg_writeback;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, mem_valid, mem_ready;
    logic [4:0]      alu_rd, mem_rd, rs1, rs2, rd;
    logic [XLEN-1:0] alu_data, mem_data, writeData;
    logic            busy1, busy2, regWrite;

    always #5 clk = ~clk;

    reg_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .busy1     (busy1),
        .busy2     (busy2),
        .regWrite  (regWrite),
        .rd        (rd),
        .writeData (writeData)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                          input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md,
                          input logic [4:0] r1, input logic [4:0] r2);
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        mem_valid = mv;  mem_rd = mrd;  mem_data = md;
        rs1 = r1;  rs2 = r2;
    endtask

    task automatic idle(input logic [4:0] r1);
        set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, r1, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(5'd0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic            av;
        logic [4:0]      ard;
        logic [XLEN-1:0] ad;
        logic            mv;
        logic [4:0]      mrd;
        logic [XLEN-1:0] md;
        logic [4:0]      r1, r2;
        logic            rdy, b1, b2;
        logic            we;
        logic [4:0]      wrd;
        logic [XLEN-1:0] wd;
        logic            chk;
    } vec_t;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    vec_t tbl[13];
    ent_t q[$];

    initial begin
        logic            av, mv, acc, have_w;
        logic [4:0]      ard, mrd, r1, r2, wr;
        logic [XLEN-1:0] ad, md, wdv;
        logic            e_rdy, e_b1, e_b2;
        int              k;
        ent_t            e;

        // Inputs per cycle, then combinational expectations, then registered result after the edge.
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1};
        tbl[2]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 32'h22, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h11,       1'b1};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h22,       1'b1};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h22,       1'b1};
        tbl[5]  = '{1'b1, 5'd1, 32'hA,        1'b1, 5'd7, 32'h77, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'hA,        1'b1};
        tbl[6]  = '{1'b1, 5'd2, 32'hB,        1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'hB,        1'b1};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77,       1'b1};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77,       1'b1};
        tbl[9]  = '{1'b1, 5'd0, 32'h5,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 5'd4, 32'hC,        1'b1, 5'd0, 32'h99, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'hC,        1'b1};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0};

        // Reset state, observed during and after reset.
        idle(5'd0);
        reset = 1'b1;
        tick();
        check("rst.regWrite", regWrite, 1'b0);
        check("rst.rd", rd, 5'd0);
        check("rst.writeData", writeData, '0);
        check("rst.mem_ready", mem_ready, 1'b1);
        check("rst.busy1", busy1, 1'b0);
        check("rst.busy2", busy2, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check("rst.post_regWrite", regWrite, 1'b0);

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md, tbl[i].r1, tbl[i].r2);
            #1;
            check($sformatf("vec%0d.mem_ready", i), mem_ready, tbl[i].rdy);
            check($sformatf("vec%0d.busy1", i), busy1, tbl[i].b1);
            check($sformatf("vec%0d.busy2", i), busy2, tbl[i].b2);
            tick();
            check($sformatf("vec%0d.regWrite", i), regWrite, tbl[i].we);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d.rd", i), rd, tbl[i].wrd);
                check($sformatf("vec%0d.writeData", i), writeData, tbl[i].wd);
            end
        end

        // Fill: ALU busy for 6 cycles while 5 loads are offered; only 4 fit.
        k = 0;
        for (int c = 0; c < 6; c++) begin
            set_in(1'b1, 5'(c + 1), 32'(c + 32'h50), 1'b1, 5'(10 + k), 32'(k + 32'h100), 5'd0, 5'd0);
            #1;
            check($sformatf("fill%0d.mem_ready", c), mem_ready, (c < 4));
            if (c < 4) k++;
            tick();
            check($sformatf("fill%0d.regWrite", c), regWrite, 1'b1);
            check($sformatf("fill%0d.rd", c), rd, 5'(c + 1));
        end
        // ALU drops while the fifth load is still offered: full, so the pop must not admit it.
        set_in(1'b0, 5'd0, '0, 1'b1, 5'd14, 32'h104, 5'd0, 5'd0);
        #1;
        check("drain0.mem_ready", mem_ready, 1'b0);
        tick();
        check("drain0.regWrite", regWrite, 1'b1);
        check("drain0.rd", rd, 5'd10);
        check("drain0.writeData", writeData, 32'h100);
        for (int j = 1; j < 4; j++) begin
            idle(5'd0);
            #1;
            check($sformatf("drain%0d.mem_ready", j), mem_ready, 1'b1);
            tick();
            check($sformatf("drain%0d.regWrite", j), regWrite, 1'b1);
            check($sformatf("drain%0d.rd", j), rd, 5'(10 + j));
            check($sformatf("drain%0d.writeData", j), writeData, 32'(j + 32'h100));
        end
        idle(5'd0);
        tick();
        check("drain_end.regWrite", regWrite, 1'b0);
        check("drain_end.mem_ready", mem_ready, 1'b1);

        // Reset with three queued loads.
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'(8 + c), 32'(c), 5'd0, 5'd0);
            tick();
        end
        idle(5'd8);
        #1;
        check("midrst.busy1_before", busy1, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst.regWrite", regWrite, 1'b0);
        check("midrst.rd", rd, 5'd0);
        check("midrst.busy1", busy1, 1'b0);
        check("midrst.mem_ready", mem_ready, 1'b1);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("postrst%0d.regWrite", c), regWrite, 1'b0);
        end
        // Count restarted at zero: exactly DEPTH more loads fit.
        for (int c = 0; c < 5; c++) begin
            set_in(1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'h9, 5'd0, 5'd0);
            #1;
            check($sformatf("postrst_fill%0d.mem_ready", c), mem_ready, (c < 4));
            tick();
        end
        do_reset();

        // Single load on an idle unit.
        set_in(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'hABC, 5'd0, 5'd0);
        #1;
        check("single.mem_ready", mem_ready, 1'b1);
        tick();
`ifdef WB_BYPASS_EN
        check("single.n1_regWrite", regWrite, 1'b1);
        check("single.n1_rd", rd, 5'd9);
        check("single.n1_writeData", writeData, 32'hABC);
        idle(5'd9);
        #1;
        check("single.busy1", busy1, 1'b0);
        tick();
        check("single.n2_regWrite", regWrite, 1'b0);
`else
        check("single.n1_regWrite", regWrite, 1'b0);
        idle(5'd9);
        #1;
        check("single.busy1", busy1, 1'b1);
        tick();
        check("single.n2_regWrite", regWrite, 1'b1);
        check("single.n2_rd", rd, 5'd9);
        check("single.n2_writeData", writeData, 32'hABC);
        #1;
        check("single.busy1_after", busy1, 1'b0);
`endif

        // Random traffic against a queue model of the arbitration rules.
        do_reset();
        q.delete();
        for (int c = 0; c < 600; c++) begin
            av  = ($urandom_range(0, 99) < 55);
            ard = 5'($urandom_range(0, 7));
            ad  = $urandom;
            mv  = ($urandom_range(0, 99) < 60);
            mrd = 5'($urandom_range(0, 7));
            md  = $urandom;
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            set_in(av, ard, ad, mv, mrd, md, r1, r2);

            e_rdy = (q.size() < DEPTH);
            e_b1  = 1'b0;
            e_b2  = 1'b0;
            foreach (q[n]) begin
                if (r1 != 5'd0 && q[n].rd == r1) e_b1 = 1'b1;
                if (r2 != 5'd0 && q[n].rd == r2) e_b2 = 1'b1;
            end
            #1;
            check("rnd.mem_ready", mem_ready, e_rdy);
            check("rnd.busy1", busy1, e_b1);
            check("rnd.busy2", busy2, e_b2);

            acc    = mv && e_rdy;
            have_w = 1'b0;
            wr     = 5'd0;
            wdv    = '0;
            if (av) begin
                have_w = 1'b1; wr = ard; wdv = ad;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                have_w = 1'b1; wr = e.rd; wdv = e.data;
            end
`ifdef WB_BYPASS_EN
            else if (acc) begin
                have_w = 1'b1; wr = mrd; wdv = md; acc = 1'b0;
            end
`endif
            if (acc) q.push_back('{mrd, md});

            tick();
            check("rnd.regWrite", regWrite, have_w && (wr != 5'd0));
            if (have_w && wr != 5'd0) begin
                check("rnd.rd", rd, wr);
                check("rnd.writeData", writeData, wdv);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DEPTH, default 4, memory-result FIFO depth; power of two, minimum 2.
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 alu_valid  input  1  ALU result present this cycle; ALU path never stalls.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  XLEN  ALU result.
REQ-008 mem_valid  input  1  load result offered.
REQ-009 mem_rd  input  5  load destination register.
REQ-010 mem_data  input  XLEN  load result.
REQ-011 mem_ready  output  1  load result accepted when mem_valid and mem_ready are both high.
REQ-012 rs1, rs2  input  5 each  hazard query registers.
REQ-013 busy1, busy2  output  1 each  query register has a write pending in the FIFO.
REQ-014 regWrite  output  1  register-file write enable, registered.
REQ-015 rd  output  5  register-file write address, registered.
REQ-016 writeData  output  XLEN  register-file write data, registered.

Function
REQ-017 Serializes two result producers onto the single register-file write port; one write per cycle maximum.
REQ-018 ALU has absolute priority: alu_valid at cycle N -> regWrite=1, rd=alu_rd, writeData=alu_data during cycle N+1.
REQ-019 Accepted load results are pushed into an in-order FIFO of DEPTH entries (rd, data).
REQ-020 FIFO head is popped to the output register in any cycle where alu_valid=0 and the FIFO is non-empty; the load write is visible the following cycle.
REQ-021 Minimum load latency without bypass: accepted cycle N -> regWrite in cycle N+2.
REQ-022 mem_ready = (count < DEPTH), combinational from registered count only; no dependence on mem_valid.
REQ-023 Full: mem_ready=0 and no push; a pop in the same cycle does not allow a push that cycle.
REQ-024 Simultaneous push and pop when not full: count unchanged; the pushed entry goes behind the existing entries.
REQ-025 Empty and alu_valid=0 with no bypass: regWrite=0 next cycle; rd and writeData hold their previous values.
REQ-026 Any write with destination 0 (ALU or load) is consumed normally but produces regWrite=0.
REQ-027 ALU and load to the same rd in the same cycle: ALU is written first and the load later, so the load value is final.
REQ-028 busyX = (rsX != 0) and rsX matches rd of any valid FIFO entry; combinational; the output stage is not included.
REQ-029 Pointers wrap modulo DEPTH; count range 0..DEPTH.

Reset
REQ-030 On reset: regWrite=0, rd=0, writeData=0, count=0, pointers=0, busy1=busy2=0, mem_ready=1.
REQ-031 Reset asserted mid-operation discards all FIFO entries and any pending output write; no write is issued in the cycle after reset is released unless alu_valid was high in that first cycle.

Configuration
REQ-032 Macro WB_BYPASS_EN, when defined: a load accepted while the FIFO is empty and alu_valid=0 goes directly to the output register (regWrite in cycle N+1) without entering the FIFO, and busy is never asserted for it.
REQ-033 Without WB_BYPASS_EN: every accepted load passes through the FIFO (REQ-021 latency).

Verification
REQ-034 ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle regWrite=1, rd=5, writeData=0xDEADBEEF.
REQ-035 Conflict: ALU (rd=3, 0x11) and load (rd=3, 0x22) in the same cycle -> cycle+1 writes 0x11, cycle+2 writes 0x22 (rd=3 each).
REQ-036 Fill: alu_valid=1 continuously for 6 cycles while offering 5 loads -> mem_ready drops after 4 accepts; drop ALU -> 4 loads written in order on consecutive cycles, then mem_ready=1.
REQ-037 Hazard: push load rd=7, then query rs1=7, rs2=0 while it is queued -> busy1=1, busy2=0; busy1 falls on the cycle after the pop.
REQ-038 rd=0: ALU rd=0, data 0x5 -> regWrite stays 0; a load to rd=0 is accepted and dropped.
REQ-039 Reset with 3 queued loads -> no writes after release, count=0, mem_ready=1; bypass build: a single load on an idle unit -> regWrite at N+1.
